decode2_dispatch: RTL and testbench

Parametrised second-stage decode and dispatch queue for the 603 core. It accepts up to IW instructions per cycle from first-stage decode and classifies each into one of four execution classes: branch/jump, integer, memory, or mult/div. Classified instructions are buffered in a DEPTH-entry in-order queue and dispatched up to DW per cycle to per-unit valid/ready issue ports. It generalises the single-instruction, unbuffered, purely combinational stage-2 decode to multi-wide, buffered, flushable operation, and adds illegal-opcode trapping.

---
 rtl/decode2_pkg.sv | 56 +++++
 rtl/decode2_if.sv | 35 +++
 rtl/decode2_classify.sv | 42 ++++
 rtl/decode2_dispatch.sv | 131 +++++++++++++
 tb/tb_decode2_dispatch.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode2_pkg.sv
// Shared types and constants for the stage-2 decode/dispatch queue.
//   unit_e   : execution class of a decoded instruction (BJ/INT/MEM/MD/ILL)
//   UNIT_*   : unit port indices on the dispatch side
//   OP_*/XO_*: primary opcode and opcode-31 extended opcode values
//   entry_t  : one queue entry {ins, pc, cls}
package decode2_pkg;

    typedef enum logic [2:0] {
        BJ  = 3'd0,
        INT = 3'd1,
        MEM = 3'd2,
        MD  = 3'd3,
        ILL = 3'd4
    } unit_e;

    localparam int UNIT_BJ   = 0;
    localparam int UNIT_INT  = 1;
    localparam int UNIT_MEM  = 2;
    localparam int UNIT_MD   = 3;
    localparam int NUM_UNITS = 4;

    localparam logic [5:0] OP_MULLI    = 6'd7;
    localparam logic [5:0] OP_INT_A_LO = 6'd10;
    localparam logic [5:0] OP_INT_A_HI = 6'd15;
    localparam logic [5:0] OP_BC       = 6'd16;
    localparam logic [5:0] OP_B        = 6'd18;
    localparam logic [5:0] OP_XL       = 6'd19;
    localparam logic [5:0] OP_RLWIMI   = 6'd20;
    localparam logic [5:0] OP_RLWINM   = 6'd21;
    localparam logic [5:0] OP_INT_B_LO = 6'd23;
    localparam logic [5:0] OP_INT_B_HI = 6'd29;
    localparam logic [5:0] OP_X        = 6'd31;
    localparam logic [5:0] OP_MEM_LO   = 6'd32;
    localparam logic [5:0] OP_MEM_HI   = 6'd55;

    // Opcode-31 indexed loads/stores.
    localparam int XO_MEM_N = 18;
    localparam logic [9:0] XO_MEM [XO_MEM_N] = '{
        10'd23,  10'd55,  10'd87,  10'd119, 10'd151, 10'd183,
        10'd215, 10'd247, 10'd279, 10'd311, 10'd343, 10'd375,
        10'd407, 10'd439, 10'd534, 10'd662, 10'd790, 10'd918
    };

    // Opcode-31 multiply/divide.
    localparam int XO_MD_N = 5;
    localparam logic [9:0] XO_MD [XO_MD_N] = '{
        10'd11, 10'd75, 10'd235, 10'd459, 10'd491
    };

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        unit_e       cls;
    } entry_t;

endpackage

// File: rtl/decode2_if.sv
// Handshake bundle between first-stage decode, the dispatch queue and the
// execution units.
//   in_valid/in_ins/in_pc/in_ready : IW-wide enqueue side
//   flush                          : synchronous queue flush
//   unit_valid/ready/ins/pc        : per-unit issue ports (0=BJ 1=INT 2=MEM 3=MD)
//   exc_valid/exc_pc               : illegal instruction at the queue head
// master = producer/units side, slave = dispatch queue.
interface decode2_if #(
    parameter int IW = 2
);
    import decode2_pkg::*;

    logic [IW-1:0]                  in_valid;
    logic [IW-1:0][31:0]            in_ins;
    logic [IW-1:0][31:0]            in_pc;
    logic                           in_ready;
    logic                           flush;
    logic [NUM_UNITS-1:0]           unit_valid;
    logic [NUM_UNITS-1:0]           unit_ready;
    logic [NUM_UNITS-1:0][31:0]     unit_ins;
    logic [NUM_UNITS-1:0][31:0]     unit_pc;
    logic                           exc_valid;
    logic [31:0]                    exc_pc;

    modport master (
        output in_valid, in_ins, in_pc, flush, unit_ready,
        input  in_ready, unit_valid, unit_ins, unit_pc, exc_valid, exc_pc
    );

    modport slave (
        input  in_valid, in_ins, in_pc, flush, unit_ready,
        output in_ready, unit_valid, unit_ins, unit_pc, exc_valid, exc_pc
    );

endinterface

// File: rtl/decode2_classify.sv
// Purely combinational instruction classifier.
//   ins : 32-bit instruction word
//   cls : execution class (BJ, INT, MEM, MD or ILL)
module decode2_classify
    import decode2_pkg::*;
(
    input  logic [31:0] ins,
    output unit_e       cls
);

    logic [5:0] op;
    logic [9:0] xo;
    logic       unused_bits;

    assign op          = ins[31:26];
    assign xo          = ins[10:1];
    assign unused_bits = ^{ins[25:11], ins[0]};

    always_comb begin
        cls = ILL;
        if (op == OP_BC || op == OP_B || op == OP_XL) begin
            cls = BJ;
        end else if (op >= OP_MEM_LO && op <= OP_MEM_HI) begin
            cls = MEM;
        end else if (op == OP_MULLI) begin
            cls = MD;
        end else if ((op >= OP_INT_A_LO && op <= OP_INT_A_HI) || op == OP_RLWIMI ||
                     op == OP_RLWINM || (op >= OP_INT_B_LO && op <= OP_INT_B_HI)) begin
            cls = INT;
        end else if (op == OP_X) begin
            // Any opcode-31 form that is not a memory or mult/div op is integer.
            cls = INT;
            for (int i = 0; i < XO_MEM_N; i++) begin
                if (xo == XO_MEM[i]) cls = MEM;
            end
            for (int i = 0; i < XO_MD_N; i++) begin
                if (xo == XO_MD[i]) cls = MD;
            end
        end
    end

endmodule

// File: rtl/decode2_dispatch.sv
// Stage-2 decode and in-order dispatch queue.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : decode2_if.slave -- enqueue lanes, flush, per-unit issue
//                ports and illegal-instruction exception report
// Up to IW contiguous lanes are classified and written per cycle into a
// DEPTH-entry ring; up to DW entries leave per cycle, at most one per unit.
module decode2_dispatch
    import decode2_pkg::*;
#(
    parameter int IW    = 2,
    parameter int DEPTH = 8,
    parameter int DW    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    decode2_if.slave     bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = $clog2(IW + 1);

    entry_t                q [DEPTH];
    logic   [AW-1:0]       head;
    logic   [AW-1:0]       tail;
    logic   [CW-1:0]       count;

    unit_e                 lane_cls [IW];
    entry_t                wr [IW];
    logic   [EW-1:0]       enq;
    logic   [1:0]          deq;
    logic                  in_ready;

    entry_t                e0;
    entry_t                e1;
    logic   [2:0]          c0;
    logic   [2:0]          c1;
    logic                  off0;
    logic                  off1;
    logic                  fire0;
    logic                  fire1;
    logic   [NUM_UNITS-1:0]       uv;
    logic   [NUM_UNITS-1:0][31:0] uins;
    logic   [NUM_UNITS-1:0][31:0] upc;
    logic                  exc_valid;

    // Enqueue: classify every lane, then take lanes up to the first gap.
    for (genvar g = 0; g < IW; g++) begin : g_lane
        decode2_classify u_classify (
            .ins (bus.in_ins[g]),
            .cls (lane_cls[g])
        );
    end

    assign in_ready = (CW'(DEPTH) - count) >= CW'(IW);

    always_comb begin
        logic gap;
        gap = 1'b0;
        enq = '0;
        for (int i = 0; i < IW; i++) begin
            wr[i] = '{ins: bus.in_ins[i], pc: bus.in_pc[i], cls: lane_cls[i]};
            if (bus.in_valid[i] && !gap) enq = EW'(i + 1);
            else                         gap = 1'b1;
        end
        if (!in_ready || bus.flush) enq = '0;
    end

    // Dispatch: slot 1 rides along only when slot 0 actually fires and it
    // targets a different unit, which keeps issue in order and one-per-unit.
    assign e0 = q[head];
    assign e1 = q[head + AW'(1)];
    assign c0 = e0.cls;
    assign c1 = e1.cls;

    always_comb begin
        off0  = (count != '0) && (c0 != ILL) && !bus.flush;
        fire0 = off0 && bus.unit_ready[c0[1:0]];
        off1  = (DW == 2) && (count >= CW'(2)) && fire0 && (c1 != c0) && (c1 != ILL);
        fire1 = off1 && bus.unit_ready[c1[1:0]];

        uv   = '0;
        uins = '0;
        upc  = '0;
        if (off0) begin
            uv[c0[1:0]]   = 1'b1;
            uins[c0[1:0]] = e0.ins;
            upc[c0[1:0]]  = e0.pc;
        end
        if (off1) begin
            uv[c1[1:0]]   = 1'b1;
            uins[c1[1:0]] = e1.ins;
            upc[c1[1:0]]  = e1.pc;
        end

        exc_valid = (count != '0) && (c0 == ILL) && !bus.flush;
        deq       = {1'b0, fire0} + {1'b0, fire1};
    end

    assign bus.in_ready   = in_ready;
    assign bus.unit_valid = uv;
    assign bus.unit_ins   = uins;
    assign bus.unit_pc    = upc;
    assign bus.exc_valid  = exc_valid;
    assign bus.exc_pc     = e0.pc;

    // Pointer/count state: the only reset state in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq);
            tail  <= tail + AW'(enq);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // Queue storage: contents are meaningful only below count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IW; i++) begin
            if (EW'(i) < enq) q[tail + AW'(i)] <= wr[i];
        end
    end

endmodule

// File: tb/tb_decode2_dispatch.sv
// Self-checking bench for decode2_dispatch (IW=2, DEPTH=8, DW=2).
// A queue-level reference model predicts every cycle's issue ports,
// exception report, in_ready and occupancy.
module tb_decode2_dispatch;
    import decode2_pkg::*;

    localparam int IW    = 2;
    localparam int DEPTH = 8;
    localparam int DW    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode2_if #(.IW(IW)) bus ();

    decode2_dispatch #(.IW(IW), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [2:0]  cls;
    } ment_t;

    typedef struct packed {
        logic [3:0]       uv;
        logic [3:0][31:0] ins;
        logic [3:0][31:0] pc;
        logic             exc;
        logic [31:0]      epc;
        logic             rdy;
    } obs_t;

    ment_t mq[$];
    obs_t  exp_o, obs_o;
    int    exp_count;
    int    vectors     = 0;
    int    miscompares = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    // Class from the architectural opcode tables: 0=BJ 1=INT 2=MEM 3=MD 4=ILL.
    function automatic logic [2:0] m_cls(input logic [31:0] ins);
        int op, xo;
        op = int'(ins[31:26]);
        xo = int'(ins[10:1]);
        if (op inside {16, 18, 19})                  return 3'd0;
        if (op inside {[32:55]})                     return 3'd2;
        if (op == 7)                                 return 3'd3;
        if (op inside {[10:15], 20, 21, [23:29]})    return 3'd1;
        if (op == 31) begin
            if (xo inside {23, 55, 87, 119, 151, 183, 215, 247, 279, 311,
                           343, 375, 407, 439, 534, 662, 790, 918}) return 3'd2;
            if (xo inside {11, 75, 235, 459, 491})   return 3'd3;
            return 3'd1;
        end
        return 3'd4;
    endfunction

    function automatic logic [31:0] rand_ins(input bit allow_ill);
        logic [31:0] r;
        logic [5:0]  op;
        logic [9:0]  xo;
        r  = $urandom;
        xo = r[10:1];
        op = 6'd14;
        case ($urandom_range(0, allow_ill ? 8 : 7))
            0: op = 6'd18;
            1: op = 6'd19;
            2: op = 6'(10 + $urandom_range(0, 5));
            3: op = 6'(32 + $urandom_range(0, 23));
            4: op = 6'd7;
            5: begin
                op = 6'd31;
                case ($urandom_range(0, 3))
                    0: xo = 10'd23;
                    1: xo = 10'd215;
                    2: xo = 10'd534;
                    default: xo = 10'd918;
                endcase
            end
            6: begin
                op = 6'd31;
                xo = ($urandom_range(0, 1) == 0) ? 10'd235 : 10'd491;
            end
            7: op = 6'd31;
            default: op = 6'($urandom_range(0, 6));
        endcase
        return {op, r[25:11], xo, r[0]};
    endfunction

    function automatic logic [31:0] next_pc();
        pc_ctr = pc_ctr + 32'd4;
        return pc_ctr;
    endfunction

    function automatic obs_t observe();
        obs_t o = '0;
        o.uv  = bus.unit_valid;
        o.exc = bus.exc_valid;
        o.rdy = bus.in_ready;
        if (exp_o.exc) o.epc = bus.exc_pc;
        for (int u = 0; u < 4; u++) begin
            if (exp_o.uv[u]) begin
                o.ins[u] = bus.unit_ins[u];
                o.pc[u]  = bus.unit_pc[u];
            end
        end
        return o;
    endfunction

    // One clock: drive at the falling edge, sample 1 ns later, then advance
    // the model to what the queue should hold after the next rising edge.
    task automatic step(input logic [IW-1:0] v, input logic [IW-1:0][31:0] ins,
                        input logic [IW-1:0][31:0] pc, input logic [3:0] rdy,
                        input logic fl);
        int npop;
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_ins     = ins;
        bus.in_pc      = pc;
        bus.unit_ready = rdy;
        bus.flush      = fl;
        #1;
        exp_o     = '0;
        exp_count = mq.size();
        exp_o.rdy = ((DEPTH - mq.size()) >= IW);
        npop      = 0;
        if (!fl && mq.size() >= 1) begin
            if (mq[0].cls == 3'd4) begin
                exp_o.exc = 1'b1;
                exp_o.epc = mq[0].pc;
            end else begin
                exp_o.uv[mq[0].cls]  = 1'b1;
                exp_o.ins[mq[0].cls] = mq[0].ins;
                exp_o.pc[mq[0].cls]  = mq[0].pc;
                if (rdy[mq[0].cls]) begin
                    npop = 1;
                    if (DW == 2 && mq.size() >= 2 && mq[1].cls != mq[0].cls && mq[1].cls != 3'd4) begin
                        exp_o.uv[mq[1].cls]  = 1'b1;
                        exp_o.ins[mq[1].cls] = mq[1].ins;
                        exp_o.pc[mq[1].cls]  = mq[1].pc;
                        if (rdy[mq[1].cls]) npop = 2;
                    end
                end
            end
        end
        obs_o = observe();
        if (fl) begin
            mq.delete();
        end else begin
            repeat (npop) void'(mq.pop_front());
            if (exp_o.rdy) begin
                for (int k = 0; k < IW; k++) begin
                    if (!v[k]) break;
                    mq.push_back(ment_t'{ins: ins[k], pc: pc[k], cls: m_cls(ins[k])});
                end
            end
        end
    endtask

    task automatic idle(input logic [3:0] rdy);
        step('0, '0, '0, rdy, 1'b0);
    endtask

    task automatic test_reset();
        bus.in_valid = '0; bus.in_ins = '0; bus.in_pc = '0;
        bus.unit_ready = '0; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.unit_valid !== 4'b0 || bus.exc_valid !== 1'b0 || dut.count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state rdy=%b uv=%b exc=%b count=%0d required rdy=1 uv=0000 exc=0 count=0",
                     bus.in_ready, bus.unit_valid, bus.exc_valid, dut.count);
        end
        rst_n = 1'b1;
        idle(4'hF);
        vectors++;
        if (obs_o !== exp_o) begin miscompares++; $display("FAIL reset_idle got=%h exp=%h", obs_o, exp_o); end
    endtask

    task automatic test_pair();
        logic [IW-1:0][31:0] i2, p2;
        i2 = {32'h8001_0008, 32'h3821_0004};
        p2 = {32'h0000_0104, 32'h0000_0100};
        step(2'b11, i2, p2, 4'hF, 1'b0);
        vectors++;
        if (obs_o !== exp_o) begin miscompares++; $display("FAIL pair_push got=%h exp=%h", obs_o, exp_o); end
        idle(4'hF);
        vectors++;
        if (bus.unit_valid !== 4'b0110 || bus.unit_ins[1] !== 32'h3821_0004 || bus.unit_ins[2] !== 32'h8001_0008) begin
            miscompares++;
            $display("FAIL pair_offer uv=%b ins1=%h ins2=%h required uv=0110 ins1=38210004 ins2=80010008",
                     bus.unit_valid, bus.unit_ins[1], bus.unit_ins[2]);
        end
        vectors++;
        if (obs_o !== exp_o) begin miscompares++; $display("FAIL pair_model got=%h exp=%h", obs_o, exp_o); end
        idle(4'hF);
        vectors++;
        if (dut.count !== 4'd0) begin miscompares++; $display("FAIL pair_drained count=%0d required 0", dut.count); end
    endtask

    task automatic test_same_class();
        logic [IW-1:0][31:0] i2, p2;
        i2 = {32'h3821_0004, 32'h3821_0004};
        p2 = {32'h0000_2004, 32'h0000_2000};
        step(2'b11, i2, p2, 4'hF, 1'b0);
        for (int c = 0; c < 2; c++) begin
            idle(4'hF);
            vectors++;
            if (bus.unit_valid !== 4'b0010 || bus.unit_pc[1] !== p2[c]) begin
                miscompares++;
                $display("FAIL same_class_c%0d uv=%b pc1=%h required uv=0010 pc1=%h", c, bus.unit_valid, bus.unit_pc[1], p2[c]);
            end
            vectors++;
            if (obs_o !== exp_o) begin miscompares++; $display("FAIL same_class_model got=%h exp=%h", obs_o, exp_o); end
        end
        idle(4'hF);
        vectors++;
        if (obs_o !== exp_o) begin miscompares++; $display("FAIL same_class_empty got=%h exp=%h", obs_o, exp_o); end
    endtask

    task automatic test_fill_drain();
        int prev, cur;
        step(2'b01, {32'h0, rand_ins(0)}, {32'h0, next_pc()}, 4'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(2'b11, {rand_ins(0), rand_ins(0)}, {next_pc(), next_pc()}, 4'h0, 1'b0);
            vectors++;
            if (obs_o !== exp_o) begin miscompares++; $display("FAIL fill_model got=%h exp=%h", obs_o, exp_o); end
        end
        vectors++;
        if (bus.in_ready !== 1'b0 || dut.count !== 4'd7) begin
            miscompares++;
            $display("FAIL fill_full rdy=%b count=%0d required rdy=0 count=7", bus.in_ready, dut.count);
        end
        prev = int'(dut.count);
        for (int c = 0; c < 20; c++) begin
            step(2'b11, {rand_ins(0), rand_ins(0)}, {next_pc(), next_pc()}, 4'hF, 1'b0);
            cur = int'(dut.count);
            vectors++;
            if (obs_o !== exp_o || cur != exp_count) begin
                miscompares++;
                $display("FAIL drain_model got=%h exp=%h count=%0d exp_count=%0d", obs_o, exp_o, cur, exp_count);
            end
            vectors++;
            if (cur < prev - 2) begin miscompares++; $display("FAIL drain_rate count=%0d prev=%0d required drop<=2", cur, prev); end
            prev = cur;
        end
    endtask

    task automatic test_illegal();
        logic [IW-1:0][31:0] i2, p2;
        idle(4'h0);
        step('0, '0, '0, 4'hF, 1'b1);
        i2 = {32'h3821_0004, 32'h0000_0000};
        p2 = {32'h0000_3004, 32'h0000_3000};
        step(2'b11, i2, p2, 4'hF, 1'b0);
        for (int c = 0; c < 4; c++) begin
            idle(4'hF);
            vectors++;
            if (bus.exc_valid !== 1'b1 || bus.exc_pc !== 32'h0000_3000 || bus.unit_valid !== 4'b0) begin
                miscompares++;
                $display("FAIL illegal_hold exc=%b pc=%h uv=%b required exc=1 pc=00003000 uv=0000",
                         bus.exc_valid, bus.exc_pc, bus.unit_valid);
            end
            vectors++;
            if (obs_o !== exp_o) begin miscompares++; $display("FAIL illegal_model got=%h exp=%h", obs_o, exp_o); end
        end
        step('0, '0, '0, 4'hF, 1'b1);
        vectors++;
        if (bus.exc_valid !== 1'b0 || bus.unit_valid !== 4'b0) begin
            miscompares++;
            $display("FAIL illegal_flush exc=%b uv=%b required exc=0 uv=0000", bus.exc_valid, bus.unit_valid);
        end
        idle(4'hF);
        vectors++;
        if (obs_o !== exp_o || dut.count !== 4'd0) begin
            miscompares++;
            $display("FAIL illegal_after got=%h exp=%h count=%0d", obs_o, exp_o, dut.count);
        end
    endtask

    task automatic test_flush_push();
        step(2'b11, {rand_ins(0), rand_ins(0)}, {next_pc(), next_pc()}, 4'h0, 1'b0);
        step(2'b11, {rand_ins(0), rand_ins(0)}, {next_pc(), next_pc()}, 4'h0, 1'b0);
        step(2'b11, {32'h3821_0004, 32'h8001_0008}, {32'h0000_4004, 32'h0000_4000}, 4'h0, 1'b1);
        vectors++;
        if (bus.unit_valid !== 4'b0 || obs_o !== exp_o) begin
            miscompares++;
            $display("FAIL flush_cycle uv=%b got=%h exp=%h", bus.unit_valid, obs_o, exp_o);
        end
        for (int c = 0; c < 3; c++) begin
            idle(4'hF);
            vectors++;
            if (dut.count !== 4'd0 || bus.unit_valid !== 4'b0) begin
                miscompares++;
                $display("FAIL flush_after count=%0d uv=%b required count=0 uv=0000", dut.count, bus.unit_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        step(2'b11, {32'h3821_0004, 32'h8001_0008}, {next_pc(), next_pc()}, 4'h0, 1'b0);
        step(2'b11, {32'h4800_0010, 32'h7C00_01D6}, {next_pc(), next_pc()}, 4'h0, 1'b0);
        idle(4'h0);
        vectors++;
        if (obs_o !== exp_o || dut.count !== 4'd4) begin
            miscompares++;
            $display("FAIL async_prefill got=%h exp=%h count=%0d required 4", obs_o, exp_o, dut.count);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.unit_valid !== 4'b0 || bus.exc_valid !== 1'b0 || bus.in_ready !== 1'b1 || dut.count !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset uv=%b exc=%b rdy=%b count=%0d required uv=0000 exc=0 rdy=1 count=0",
                     bus.unit_valid, bus.exc_valid, bus.in_ready, dut.count);
        end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4'hF);
        vectors++;
        if (bus.in_ready !== 1'b1 || obs_o !== exp_o) begin
            miscompares++;
            $display("FAIL async_release rdy=%b got=%h exp=%h", bus.in_ready, obs_o, exp_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(IW'($urandom), {rand_ins(1), rand_ins(1)}, {next_pc(), next_pc()},
                 4'($urandom), ($urandom_range(0, 11) == 0));
            vectors++;
            if (obs_o !== exp_o || int'(dut.count) != exp_count) begin
                miscompares++;
                $display("FAIL random_c%0d got=%h exp=%h count=%0d exp_count=%0d", c, obs_o, exp_o, dut.count, exp_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_same_class();
        test_fill_drain();
        test_illegal();
        test_flush_push();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
